// File: rtl/aurora_tx_sched.sv
// Round-robin scheduler for the Aurora TX lane: pops one DFX word from an enabled,
// non-empty output queue and streams it LSB-beat-first as 64-bit valid/ready beats.
module aurora_tx_sched #(
  parameter int unsigned NUM_PORTS         = 4,
  parameter int unsigned DATA_WIDTH        = 1024,
  parameter int unsigned ADDR_WIDTH        = 10,
  parameter int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int unsigned AURORA_DATA_WIDTH = 64,
  localparam int unsigned PID_W            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                port_en,
  input  logic [NUM_PORTS-1:0]                empty_output_queue,
  output logic [NUM_PORTS-1:0]                rd_output_queue,
  input  logic [NUM_PORTS*DATA_DFX_WIDTH-1:0] data_output_queue,
  output logic [AURORA_DATA_WIDTH-1:0]        tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                tx_last,
  output logic [PID_W-1:0]                    tx_port_id,
  output logic                                busy,
  output logic                                done_pkt
);

  localparam int unsigned BEATS = (DATA_DFX_WIDTH + AURORA_DATA_WIDTH - 1) / AURORA_DATA_WIDTH;
  localparam int unsigned SH_W  = BEATS * AURORA_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, POP, CAP, SEND} state_t;

  state_t                 state_q, state_d;
  logic [PID_W-1:0]       last_grant_q, last_grant_d;
  logic [PID_W-1:0]       port_id_q, port_id_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [SH_W-1:0]        shreg_q, shreg_d;
  logic [NUM_PORTS-1:0]   rd_q, rd_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   tx_last_q, tx_last_d;
  logic                   busy_q, busy_d;

  logic [NUM_PORTS-1:0]   req_c;
  logic [PID_W-1:0]       grant_c;
  logic                   found_c;
  logic                   hs_c;
  int unsigned            idx_c;
  int unsigned            base_c;

  // Round-robin search upward from the port after last_grant, wrapping.
  always_comb begin
    req_c   = ~empty_output_queue & port_en;
    grant_c = last_grant_q;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx_c = 32'(last_grant_q) + i;
      if (idx_c >= NUM_PORTS) idx_c = idx_c - NUM_PORTS;
      if (!found_c && req_c[idx_c[PID_W-1:0]]) begin
        found_c = 1'b1;
        grant_c = idx_c[PID_W-1:0];
      end
    end
  end

  assign hs_c   = tx_valid_q & tx_ready;
  assign base_c = 32'(port_id_q) * DATA_DFX_WIDTH;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_id_d    = port_id_q;
    beat_cnt_d   = beat_cnt_q;
    shreg_d      = shreg_q;
    rd_d         = '0;
    tx_valid_d   = 1'b0;
    tx_last_d    = 1'b0;
    busy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d          = POP;
          port_id_d        = grant_c;
          rd_d[grant_c]    = 1'b1;
        end
      end
      POP:  state_d = CAP;
      CAP: begin
        shreg_d    = SH_W'(data_output_queue[base_c +: DATA_DFX_WIDTH]);
        beat_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (hs_c) begin
          shreg_d    = shreg_q >> AURORA_DATA_WIDTH;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (tx_last_q) begin
            last_grant_d = port_id_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tx_valid_d = (state_d == SEND);
    tx_last_d  = (state_d == SEND) && (beat_cnt_d == CNT_W'(BEATS - 1));
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PID_W'(NUM_PORTS - 1);
      port_id_q    <= '0;
      beat_cnt_q   <= '0;
      shreg_q      <= '0;
      rd_q         <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_id_q    <= port_id_d;
      beat_cnt_q   <= beat_cnt_d;
      shreg_q      <= shreg_d;
      rd_q         <= rd_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_output_queue = rd_q;
  assign tx_data         = shreg_q[AURORA_DATA_WIDTH-1:0];
  assign tx_valid        = tx_valid_q;
  assign tx_last         = tx_last_q;
  assign tx_port_id      = port_id_q;
  assign busy            = busy_q;
  // Completion coincides with the final-beat handshake; suppressed while reset is applied.
  assign done_pkt        = tx_valid_q & tx_ready & tx_last_q & ~rst;

endmodule
